// File: rtl/gpr_pkg.sv
// Shared definitions for the GPR writeback sequencer.
//   GPR_AW / XLEN : register address width and data width
//   wb_entry_t    : one queued writeback result {valid, rd, data}
//   src_e         : producer selected by the writeback arbiter
package gpr_pkg;

  localparam int GPR_AW = 5;
  localparam int XLEN   = 32;

  typedef struct packed {
    logic              valid;
    logic [GPR_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_LSU  = 2'd0,
    SRC_CSR  = 2'd1,
    SRC_ALU  = 2'd2,
    SRC_NONE = 2'd3
  } src_e;

endpackage

// File: rtl/gpr_wb_fifo.sv
// In-order writeback queue: storage, head/tail pointers and occupancy count.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_entry at tail (caller guarantees space or same-cycle pop)
//   i_entry    : entry to enqueue
//   i_pop      : retire head entry (caller guarantees count > 0)
//   o_count    : registered occupancy, 0..DEPTH
//   o_age      : entries ordered by age, index 0 = head (oldest); valid masked by count
module gpr_wb_fifo
  import gpr_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  wb_entry_t             i_entry,
  input  logic                  i_pop,
  output logic [PTR_W:0]        o_count,
  output wb_entry_t [DEPTH-1:0] o_age
);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      // Pop is written before push: when full, head == tail and the new
      // entry must win over the retiring one.
      if (i_pop) begin
        r_mem[r_head].valid <= 1'b0;
        r_head              <= r_head + 1'b1;
      end
      if (i_push) begin
        r_mem[r_tail] <= i_entry;
        r_tail        <= r_tail + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    logic [PTR_W-1:0] w_idx;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx          = r_head + PTR_W'(k);
      o_age[k]       = r_mem[w_idx];
      o_age[k].valid = r_mem[w_idx].valid && ((PTR_W+1)'(k) < r_count);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/gpr_wb.sv
// GPR writeback sequencer. Arbitrates LSU > CSR > ALU results into an
// in-order queue and drains it into the register file write port whenever
// the write slot is available. Queued values are visible to decode through
// two bypass lookups.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   lsu_/csr_/alu_{valid,rd,data}    : producer results; *_ready = accepted this cycle
//   gpr_slot                         : register file write slot available
//   gpr_we / gpr_rd / gpr_di         : register file write port (head of queue)
//   byp_ra / byp_rb                  : bypass query addresses
//   byp_hit_a/b, byp_qa/b            : youngest queued match and its data
//   wb_full / wb_idle                : queue full / empty
module gpr_wb
  import gpr_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        lsu_ready,
  input  logic        csr_valid,
  input  logic [4:0]  csr_rd,
  input  logic [31:0] csr_rdata,
  output logic        csr_ready,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        gpr_slot,
  output logic        gpr_we,
  output logic [4:0]  gpr_rd,
  output logic [31:0] gpr_di,
  input  logic [4:0]  byp_ra,
  input  logic [4:0]  byp_rb,
  output logic        byp_hit_a,
  output logic        byp_hit_b,
  output logic [31:0] byp_qa,
  output logic [31:0] byp_qb,
  output logic        wb_full,
  output logic        wb_idle
);

  logic [PTR_W:0]        w_count;
  wb_entry_t [DEPTH-1:0] w_age;
  wb_entry_t             w_entry;
  src_e                  w_src;
  logic                  w_commit;
  logic                  w_accept_ok;
  logic                  w_push;

  assign gpr_we      = (w_count != '0);
  assign gpr_rd      = gpr_we ? w_age[0].rd   : '0;
  assign gpr_di      = gpr_we ? w_age[0].data : '0;
  assign w_commit    = gpr_we && gpr_slot;
  // A full queue still accepts when the head retires on the same edge.
  assign w_accept_ok = (w_count < (PTR_W+1)'(DEPTH)) || w_commit;
  assign wb_full     = (w_count == (PTR_W+1)'(DEPTH));
  assign wb_idle     = (w_count == '0);

  always_comb begin
    w_src = SRC_NONE;
    if (lsu_valid)      w_src = SRC_LSU;
    else if (csr_valid) w_src = SRC_CSR;
    else if (alu_valid) w_src = SRC_ALU;

    lsu_ready = (w_src == SRC_LSU) && w_accept_ok;
    csr_ready = (w_src == SRC_CSR) && w_accept_ok;
    alu_ready = (w_src == SRC_ALU) && w_accept_ok;

    w_entry       = '0;
    w_entry.valid = 1'b1;
    case (w_src)
      SRC_LSU: begin w_entry.rd = lsu_rd; w_entry.data = lsu_data;  end
      SRC_CSR: begin w_entry.rd = csr_rd; w_entry.data = csr_rdata; end
      SRC_ALU: begin w_entry.rd = alu_rd; w_entry.data = alu_data;  end
      default: begin w_entry.rd = '0;     w_entry.data = '0;        end
    endcase

    // Writes to x0 complete the handshake but are discarded here.
    w_push = (w_src != SRC_NONE) && w_accept_ok && (w_entry.rd != '0);
  end

  gpr_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_commit),
    .o_count (w_count),
    .o_age   (w_age)
  );

  // Scan oldest to youngest so the youngest match overrides older ones.
  always_comb begin
    byp_hit_a = 1'b0;
    byp_hit_b = 1'b0;
    byp_qa    = '0;
    byp_qb    = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (w_age[k].valid && (w_age[k].rd == byp_ra) && (byp_ra != '0)) begin
        byp_hit_a = 1'b1;
        byp_qa    = w_age[k].data;
      end
      if (w_age[k].valid && (w_age[k].rd == byp_rb) && (byp_rb != '0)) begin
        byp_hit_b = 1'b1;
        byp_qb    = w_age[k].data;
      end
    end
  end

endmodule
